// File: rtl/keep_packer_pkg.sv
// Shared types and helpers for keep_packer: FSM state encoding, lane popcount
// and contiguous keep-mask generation, sized for up to KP_MAX_LANES lanes.
package keep_packer_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } kp_state_e;

  localparam int unsigned KP_MAX_LANES = 32;
  localparam int unsigned KP_CNT_W     = 8;

  function automatic logic [KP_CNT_W-1:0] kp_popcount(input logic [KP_MAX_LANES-1:0] v);
    logic [KP_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KP_MAX_LANES; i++) begin
      if (v[i]) n = n + KP_CNT_W'(1);
    end
    return n;
  endfunction

  // Lanes [0, n) set, everything above cleared.
  function automatic logic [KP_MAX_LANES-1:0] kp_keep_mask(input logic [KP_CNT_W-1:0] n);
    logic [KP_MAX_LANES-1:0] m;
    for (int i = 0; i < KP_MAX_LANES; i++) begin
      m[i] = (KP_CNT_W'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/keep_packer_lane_compactor.sv
// Combinational lane compactor: moves kept lanes down to the lowest indices in
// ascending order and reports how many lanes were kept.
module lane_compactor #(
  parameter int KEEP_WIDTH   = 3,
  parameter int T_DATA_WIDTH = 1,
  parameter int CNT_W        = $clog2(KEEP_WIDTH + 1)
) (
  input  logic [KEEP_WIDTH-1:0]   keep_i,
  input  logic [T_DATA_WIDTH-1:0] lanes_i [KEEP_WIDTH],
  output logic [T_DATA_WIDTH-1:0] dense_o [KEEP_WIDTH],
  output logic [CNT_W-1:0]        count_o
);
  import keep_packer_pkg::*;

  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] pos [KEEP_WIDTH];

  assign count_o = CNT_W'(kp_popcount(KP_MAX_LANES'(keep_i)));

  // pos[i] is the destination slot of lane i: number of kept lanes below it.
  always_comb begin
    acc = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      pos[i] = acc;
      if (keep_i[i]) acc = acc + CNT_W'(1);
    end
  end

  always_comb begin
    for (int o = 0; o < KEEP_WIDTH; o++) begin
      dense_o[o] = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        if (keep_i[i] && (pos[i] == CNT_W'(o))) dense_o[o] = lanes_i[i];
      end
    end
  end

endmodule

// File: rtl/keep_packer.sv
// AXI-Stream keep compactor: removes keep holes and merges lanes across beats.
// Optional statistics counters are enabled with `define KEEP_PACKER_STATS_EN.
module keep_packer #(
  parameter int KEEP_WIDTH   = 3,
  parameter int T_DATA_WIDTH = 1,
  parameter int CNT_WIDTH    = $clog2(2 * KEEP_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid_i,
  input  logic                    s_last_i,
  input  logic [KEEP_WIDTH-1:0]   s_keep_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [KEEP_WIDTH],
  output logic                    s_ready_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    m_last_o,
  output logic [KEEP_WIDTH-1:0]   m_keep_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [KEEP_WIDTH]
`ifdef KEEP_PACKER_STATS_EN
  ,
  output logic [31:0]             pkt_count_o,
  output logic [31:0]             drop_count_o
`endif
);
  import keep_packer_pkg::*;

  localparam int BUF_LANES = 2 * KEEP_WIDTH;
  localparam logic [CNT_WIDTH-1:0] KW_C = CNT_WIDTH'(KEEP_WIDTH);

  kp_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [T_DATA_WIDTH-1:0] buf_q   [BUF_LANES];
  logic [T_DATA_WIDTH-1:0] buf_d   [BUF_LANES];
  logic [T_DATA_WIDTH-1:0] shifted [BUF_LANES];
  logic [T_DATA_WIDTH-1:0] dense   [KEEP_WIDTH];
  logic [CNT_WIDTH-1:0]   pc;
  logic [CNT_WIDTH-1:0]   base;
  logic                   pop;
  logic                   push;

  lane_compactor #(
    .KEEP_WIDTH  (KEEP_WIDTH),
    .T_DATA_WIDTH(T_DATA_WIDTH),
    .CNT_W       (CNT_WIDTH)
  ) u_compactor (
    .keep_i (s_keep_i),
    .lanes_i(s_data_i),
    .dense_o(dense),
    .count_o(pc)
  );

  // Master side is decoded purely from registered state; nothing from s_* reaches m_*.
  assign m_valid_o = (state_q == FLUSH) || (cnt_q >= KW_C);
  assign m_last_o  = (state_q == FLUSH) && (cnt_q <= KW_C);

  always_comb begin
    m_keep_o = '0;
    if (state_q == FLUSH) begin
      m_keep_o = m_last_o ? KEEP_WIDTH'(kp_keep_mask(KP_CNT_W'(cnt_q))) : '1;
    end else if (m_valid_o) begin
      m_keep_o = '1;
    end
  end

  always_comb begin
    for (int i = 0; i < KEEP_WIDTH; i++) m_data_o[i] = buf_q[i];
  end

  assign pop       = m_valid_o && m_ready_i;
  assign s_ready_o = rst_n && (state_q == ACCUM) && ((cnt_q < KW_C) || pop);
  assign push      = s_valid_i && s_ready_o;

  always_comb begin
    for (int i = 0; i < BUF_LANES; i++) begin
      shifted[i] = (i < KEEP_WIDTH) ? buf_q[i + KEEP_WIDTH] : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    base    = cnt_q;
    case (state_q)
      ACCUM: begin
        if (pop) begin
          buf_d = shifted;
          base  = cnt_q - KW_C;
        end
        cnt_d = base;
        if (push) begin
          // Append the compacted lanes right after what survives the pop.
          for (int i = 0; i < BUF_LANES; i++) begin
            for (int k = 0; k < KEEP_WIDTH; k++) begin
              if (((base + CNT_WIDTH'(k)) == CNT_WIDTH'(i)) && (CNT_WIDTH'(k) < pc)) begin
                buf_d[i] = dense[k];
              end
            end
          end
          cnt_d = base + pc;
          if (s_last_i) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (m_ready_i) begin
          buf_d = shifted;
          if (m_last_o) begin
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            cnt_d = cnt_q - KW_C;
          end
        end
      end
      default: begin
        state_d = ACCUM;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      for (int i = 0; i < BUF_LANES; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

`ifdef KEEP_PACKER_STATS_EN
  logic [31:0] pkt_count_q;
  logic [31:0] drop_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (m_valid_o && m_ready_i && m_last_o) pkt_count_q <= pkt_count_q + 32'd1;
      if (push && (s_keep_i == '0) && !s_last_i) drop_count_q <= drop_count_q + 32'd1;
    end
  end

  assign pkt_count_o  = pkt_count_q;
  assign drop_count_o = drop_count_q;
`endif

endmodule

// File: doc/keep_packer.md
Name: keep_packer

Overview:
- AXI-Stream-style keep compactor placed directly upstream of the resizer slave port.
- Removes holes in the incoming s_keep pattern and merges kept lanes across beats, so the resizer only ever sees dense beats: keep all-ones, with a partial beat allowed only on the last beat of a packet.
- Same lane count on input and output; data is carried as an unpacked lane array.

Parameters:
- KEEP_WIDTH, 3, number of lanes per beat on both sides (matches resizer S_KEEP_WIDTH).
- T_DATA_WIDTH, 1, bits per lane.
- CNT_WIDTH, $clog2(2*KEEP_WIDTH+1), width of the internal lane-occupancy counter (derived; do not override).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- s_valid_i  input  1  upstream beat valid.
- s_last_i  input  1  upstream last beat of packet.
- s_keep_i  input  KEEP_WIDTH  per-lane valid; any pattern allowed.
- s_data_i  input  T_DATA_WIDTH x [KEEP_WIDTH]  upstream lanes.
- s_ready_o  output  1  upstream ready.
- m_valid_o  output  1  packed beat valid.
- m_ready_i  input  1  downstream ready.
- m_last_o  output  1  packed last.
- m_keep_o  output  KEEP_WIDTH  contiguous from lane 0 (e.g. 3'b011); all-ones unless m_last_o.
- m_data_o  output  T_DATA_WIDTH x [KEEP_WIDTH]  packed lanes, lane 0 oldest.

Behaviour:
- Storage: accumulation buffer of 2*KEEP_WIDTH lanes plus counter cnt.
- Kept input lanes are appended in ascending lane order at position cnt.
- Output lanes are buffer[0..KEEP_WIDTH-1].
- A pop shifts the buffer down by KEEP_WIDTH lanes.
- States:
  - ACCUM: collecting.
  - FLUSH: draining after an accepted last beat.
- Reset (rst_n=0 at a clock edge):
  - state=ACCUM, cnt=0, buffer zeroed.
  - m_valid_o=0, m_last_o=0, m_keep_o=0, m_data_o all zero.
  - s_ready_o=0 during reset.
  - Reset mid-packet discards all buffered lanes; there is no partial flush.
- Outputs are driven from registers: no combinational path from s_* to m_*.
- ACCUM output:
  - m_valid_o=1 iff cnt>=KEEP_WIDTH.
  - m_keep_o all-ones, m_last_o=0.
- ACCUM ready: s_ready_o = (cnt<KEEP_WIDTH) || (m_valid_o && m_ready_i).
  - This is the only combinational path (m_ready_i to s_ready_o).
  - It gives full throughput with dense input.
- Simultaneous pop and push in one cycle:
  - next cnt = cnt - KEEP_WIDTH + popcount(s_keep_i).
  - Never exceeds 2*KEEP_WIDTH-1.
- Beat with s_keep_i=0 and s_last_i=0: accepted and dropped; no state change beyond the handshake.
- Accepted beat with s_last_i=1:
  - total = (cnt after any simultaneous pop) + popcount.
  - Move to FLUSH, holding total.
- FLUSH:
  - s_ready_o=0.
  - m_valid_o=1.
  - If total>KEEP_WIDTH: emit keep all-ones, last=0; on handshake total -= KEEP_WIDTH.
  - If 0<total<=KEEP_WIDTH: emit keep = lower "total" bits set, last=1.
  - If total==0 (null last beat, packet with no data): emit keep=0, last=1. Packet boundaries are always preserved.
  - On the last=1 handshake: cnt=0, return to ACCUM.
  - Data lanes with keep=0 are don't-care but driven with buffer contents.
- Master holds m_* stable while m_valid_o && !m_ready_i.
- Latency: first output beat appears the cycle after the completing input beat is accepted.

Optional Feature:
- Macro KEEP_PACKER_STATS_EN.
- When defined:
  - Adds ports pkt_count_o (output, 32) and drop_count_o (output, 32), both reset to 0 and wrapping at 2^32.
  - pkt_count_o counts m_last_o handshakes.
  - drop_count_o counts accepted input beats with s_keep_i=0 and s_last_i=0.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package keep_packer_pkg holds:
  - state enum {ACCUM, FLUSH}.
  - A parameterised popcount function.
  - A helper producing a contiguous keep mask from a count.
- One sub-module, lane_compactor: purely combinational.
  - Inputs: keep and lanes.
  - Outputs: dense lanes (kept lanes moved to the low indices) and a count.
  - keep_packer instantiates it once on the s_* path.

Test Plan (KEEP_WIDTH=3, T_DATA_WIDTH=8):
- Sparse merge: beats keep=101 {A,x,B}, keep=010 {x,C,x} with last=1, m_ready_i held 1 -> one beat keep=111 {A,B,C}, last=1.
- Dense stream: 4 beats keep=111 with the 4th last, m_ready_i=1 -> 4 output beats, s_ready_o never drops, last on beat 4.
- Spill: cnt=2 then a last beat keep=111 -> two beats: keep=111 last=0, then keep=011 last=1 with the correct order.
- Backpressure: m_ready_i=0 for 5 cycles while cnt>=3 -> m_* stable, s_ready_o=0, no loss; release -> drains correctly.
- Null beats: keep=000 last=0 dropped; keep=000 last=1 at cnt=0 -> output keep=000 last=1; with stats, drop_count_o=1 and pkt_count_o=1.
- Reset mid-packet: rst_n=0 at cnt=2 -> next cycle all outputs at reset values; the new packet after reset carries no stale lanes.
